// File: rtl/bus_mux_lock.sv
// ============================================================================
// Module   : bus_mux_lock
// Brief    : Packet-locking registered bus mux with a 2-entry output buffer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_mux_lock #(
  parameter int DATA_WIDTH = 16,
  parameter int DATA_NUM   = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [DATA_NUM-1:0]            gate_i,
  input  logic [DATA_NUM-1:0]            up_valid_i,
  input  logic [DATA_NUM-1:0]            up_last_i,
  input  logic [DATA_WIDTH*DATA_NUM-1:0] up_data_i,
  output logic [DATA_NUM-1:0]            up_ready_o,
  output logic                           down_valid_o,
  output logic                           down_last_o,
  output logic [DATA_WIDTH-1:0]          down_data_o,
  input  logic                           down_ready_i,
  output logic                           busy_o,
  output logic                           gate_err_o
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_NUM-1:0]   lock_q, lock_d;
  logic                  gate_err_q, gate_err_d;
  logic [DATA_WIDTH:0]   mem_q [0:1];
  logic                  wr_ptr_q, rd_ptr_q;
  logic [1:0]            count_q, count_d;

  logic [DATA_NUM-1:0]   gate_low;
  logic                  gate_multi;
  logic                  sel_valid;
  logic                  sel_last;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  push;
  logic                  pop;
  logic                  has_room;

  // Isolate the lowest set bit; a nonzero remainder means multi-hot.
  assign gate_low   = gate_i & (~gate_i + {{(DATA_NUM-1){1'b0}}, 1'b1});
  assign gate_multi = (gate_i & ~gate_low) != '0;

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < DATA_NUM; i++) begin
      if (lock_q[i]) begin
        sel_valid = sel_valid | up_valid_i[i];
        sel_last  = sel_last  | up_last_i[i];
        sel_data  = sel_data  | up_data_i[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Ready depends on registered occupancy only, never on down_ready_i.
  assign has_room   = (count_q != 2'd2);
  assign up_ready_o = (state_q == LOCK && has_room) ? lock_q : '0;
  assign push       = (state_q == LOCK) && has_room && sel_valid;
  assign pop        = down_valid_o && down_ready_i;

  always_comb begin
    state_d    = state_q;
    lock_d     = lock_q;
    gate_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (gate_i != '0) begin
          state_d    = LOCK;
          lock_d     = gate_low;
          gate_err_d = gate_multi;
        end
      end
      LOCK: begin
        if (push && sel_last) begin
          state_d = IDLE;
          lock_d  = '0;
        end
      end
      default: begin
        state_d = IDLE;
        lock_d  = '0;
      end
    endcase
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      lock_q     <= '0;
      gate_err_q <= 1'b0;
      count_q    <= 2'd0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      mem_q[0]   <= '0;
      mem_q[1]   <= '0;
    end else begin
      state_q    <= state_d;
      lock_q     <= lock_d;
      gate_err_q <= gate_err_d;
      count_q    <= count_d;
      if (push) begin
        mem_q[wr_ptr_q] <= {sel_last, sel_data};
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
    end
  end

  assign down_valid_o = (count_q != 2'd0);
  assign down_last_o  = down_valid_o & mem_q[rd_ptr_q][DATA_WIDTH];
  assign down_data_o  = down_valid_o ? mem_q[rd_ptr_q][DATA_WIDTH-1:0] : '0;
  assign busy_o       = (state_q == LOCK);
  assign gate_err_o   = gate_err_q;

endmodule

`default_nettype wire

// File: tb/tb_bus_mux_lock.sv
// ============================================================================
// Module   : tb_bus_mux_lock
// Brief    : Directed self-checking bench for bus_mux_lock.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bus_mux_lock;

  localparam int DW = 16;
  localparam int DN = 4;

  logic              clk;
  logic              rst;
  logic [DN-1:0]     gate;
  logic [DN-1:0]     up_valid;
  logic [DN-1:0]     up_last;
  logic [DW*DN-1:0]  up_data;
  logic [DN-1:0]     up_ready;
  logic              down_valid;
  logic              down_last;
  logic [DW-1:0]     down_data;
  logic              down_ready;
  logic              busy;
  logic              gate_err;

  int n_vec;
  int n_err;

  bus_mux_lock #(.DATA_WIDTH(DW), .DATA_NUM(DN)) u_dut (
    .clk          (clk),
    .rst          (rst),
    .gate_i       (gate),
    .up_valid_i   (up_valid),
    .up_last_i    (up_last),
    .up_data_i    (up_data),
    .up_ready_o   (up_ready),
    .down_valid_o (down_valid),
    .down_last_o  (down_last),
    .down_data_o  (down_data),
    .down_ready_i (down_ready),
    .busy_o       (busy),
    .gate_err_o   (gate_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int ch, input logic v, input logic l, input logic [DW-1:0] d);
    up_valid[ch]         = v;
    up_last[ch]          = l;
    up_data[ch*DW +: DW] = d;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic l, input logic [DW-1:0] d);
    chk({tag, "_valid"}, {31'd0, down_valid}, {31'd0, v});
    chk({tag, "_last"},  {31'd0, down_last},  {31'd0, l});
    if (v) chk({tag, "_data"}, {16'd0, down_data}, {16'd0, d});
  endtask

  initial begin
    n_vec      = 0;
    n_err      = 0;
    rst        = 1'b1;
    gate       = '0;
    up_valid   = '0;
    up_last    = '0;
    up_data    = '0;
    down_ready = 1'b1;
    repeat (3) tick;
    rst = 1'b0;
    tick;

    // Idle: no grant, all channels valid.
    up_valid = 4'hF;
    for (int i = 0; i < 10; i++) begin
      tick;
      chk("idle_ready", {28'd0, up_ready}, 32'd0);
      chk("idle_dvalid", {31'd0, down_valid}, 32'd0);
      chk("idle_busy", {31'd0, busy}, 32'd0);
    end
    up_valid = '0;

    // Single packet on channel 2.
    gate = 4'b0100;
    tick;
    gate = '0;
    chk("sp_ready", {28'd0, up_ready}, 32'h4);
    chk("sp_busy", {31'd0, busy}, 32'd1);
    chk_out("sp_pre", 1'b0, 1'b0, 16'h0);
    set_ch(2, 1'b1, 1'b0, 16'h1111);
    tick;
    chk_out("sp_w0", 1'b1, 1'b0, 16'h1111);
    set_ch(2, 1'b1, 1'b0, 16'h2222);
    tick;
    chk_out("sp_w1", 1'b1, 1'b0, 16'h2222);
    set_ch(2, 1'b1, 1'b1, 16'h3333);
    tick;
    chk_out("sp_w2", 1'b1, 1'b1, 16'h3333);
    chk("sp_busy_end", {31'd0, busy}, 32'd0);
    set_ch(2, 1'b0, 1'b0, 16'h0);
    chk("sp_ready_end", {28'd0, up_ready}, 32'd0);
    tick;
    chk_out("sp_drain", 1'b0, 1'b0, 16'h0);

    // Grant change mid-packet: channel 3 must be ignored.
    gate = 4'b0010;
    tick;
    chk("gc_ready0", {28'd0, up_ready}, 32'h2);
    gate = 4'b1000;
    set_ch(1, 1'b1, 1'b0, 16'hA001);
    set_ch(3, 1'b1, 1'b1, 16'hDEAD);
    tick;
    chk_out("gc_w0", 1'b1, 1'b0, 16'hA001);
    chk("gc_ready1", {28'd0, up_ready}, 32'h2);
    chk("gc_err", {31'd0, gate_err}, 32'd0);
    set_ch(1, 1'b1, 1'b1, 16'hA002);
    tick;
    chk_out("gc_w1", 1'b1, 1'b1, 16'hA002);
    chk("gc_busy_end", {31'd0, busy}, 32'd0);
    chk("gc_ready2", {28'd0, up_ready}, 32'd0);
    gate = '0;
    set_ch(1, 1'b0, 1'b0, 16'h0);
    set_ch(3, 1'b0, 1'b0, 16'h0);
    tick;
    chk_out("gc_drain", 1'b0, 1'b0, 16'h0);
    chk("gc_idle", {31'd0, busy}, 32'd0);

    // Backpressure on channel 0, five words.
    down_ready = 1'b0;
    gate = 4'b0001;
    tick;
    gate = '0;
    chk("bp_ready0", {28'd0, up_ready}, 32'h1);
    set_ch(0, 1'b1, 1'b0, 16'hB001);
    tick;
    chk_out("bp_h0", 1'b1, 1'b0, 16'hB001);
    chk("bp_ready1", {28'd0, up_ready}, 32'h1);
    set_ch(0, 1'b1, 1'b0, 16'hB002);
    tick;
    chk("bp_ready_full", {28'd0, up_ready}, 32'd0);
    set_ch(0, 1'b1, 1'b0, 16'hB003);
    tick;
    chk("bp_ready_hold", {28'd0, up_ready}, 32'd0);
    chk_out("bp_h1", 1'b1, 1'b0, 16'hB001);
    down_ready = 1'b1;
    tick;
    chk_out("bp_o1", 1'b1, 1'b0, 16'hB002);
    chk("bp_ready_back", {28'd0, up_ready}, 32'h1);
    tick;
    chk_out("bp_o2", 1'b1, 1'b0, 16'hB003);
    chk("bp_count1", {30'd0, u_dut.count_q}, 32'd1);
    set_ch(0, 1'b1, 1'b0, 16'hB004);
    tick;
    chk_out("bp_o3", 1'b1, 1'b0, 16'hB004);
    set_ch(0, 1'b1, 1'b1, 16'hB005);
    tick;
    chk_out("bp_o4", 1'b1, 1'b1, 16'hB005);
    chk("bp_busy_end", {31'd0, busy}, 32'd0);
    set_ch(0, 1'b0, 1'b0, 16'h0);
    tick;
    chk_out("bp_drain", 1'b0, 1'b0, 16'h0);

    // Multi-hot grant locks the lowest channel and flags an error.
    gate = 4'b1010;
    tick;
    chk("mh_ready", {28'd0, up_ready}, 32'h2);
    chk("mh_err1", {31'd0, gate_err}, 32'd1);
    gate = '0;
    set_ch(1, 1'b1, 1'b1, 16'hC001);
    tick;
    chk("mh_err2", {31'd0, gate_err}, 32'd0);
    chk_out("mh_w0", 1'b1, 1'b1, 16'hC001);
    chk("mh_busy", {31'd0, busy}, 32'd0);
    set_ch(1, 1'b0, 1'b0, 16'h0);
    tick;
    gate = 4'b0001;
    tick;
    gate = '0;
    chk("oh_err", {31'd0, gate_err}, 32'd0);
    chk("oh_ready", {28'd0, up_ready}, 32'h1);
    set_ch(0, 1'b1, 1'b1, 16'hC002);
    tick;
    chk_out("oh_w0", 1'b1, 1'b1, 16'hC002);
    set_ch(0, 1'b0, 1'b0, 16'h0);
    tick;

    // Reset mid-packet with a full buffer.
    down_ready = 1'b0;
    gate = 4'b0100;
    tick;
    gate = '0;
    set_ch(2, 1'b1, 1'b0, 16'hD001);
    tick;
    set_ch(2, 1'b1, 1'b0, 16'hD002);
    tick;
    chk("rm_full", {30'd0, u_dut.count_q}, 32'd2);
    chk_out("rm_pre", 1'b1, 1'b0, 16'hD001);
    #3;
    rst = 1'b1;
    #1;
    chk_out("rm_rst", 1'b0, 1'b0, 16'h0);
    chk("rm_rst_data", {16'd0, down_data}, 32'd0);
    chk("rm_rst_ready", {28'd0, up_ready}, 32'd0);
    chk("rm_rst_busy", {31'd0, busy}, 32'd0);
    chk("rm_rst_err", {31'd0, gate_err}, 32'd0);
    #2;
    rst = 1'b0;
    set_ch(2, 1'b0, 1'b0, 16'h0);
    down_ready = 1'b1;
    tick;
    chk_out("rm_after", 1'b0, 1'b0, 16'h0);
    chk("rm_after_busy", {31'd0, busy}, 32'd0);
    gate = 4'b0001;
    tick;
    gate = '0;
    chk("rm_new_ready", {28'd0, up_ready}, 32'h1);
    chk_out("rm_new_pre", 1'b0, 1'b0, 16'h0);
    set_ch(0, 1'b1, 1'b1, 16'hE001);
    tick;
    chk_out("rm_new_w0", 1'b1, 1'b1, 16'hE001);
    set_ch(0, 1'b0, 1'b0, 16'h0);
    tick;
    chk_out("rm_new_drain", 1'b0, 1'b0, 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
